// File: rtl/bcd_ctrl_pkg.sv
// bcd_ctrl_pkg: shared state encoding, digit limit and helpers for the BCD stopwatch.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // v holds up to eight packed digits; only the low n digits are examined
    function automatic logic all_nines(input logic [31:0] v, input int n);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 8; i++)
            if (i < n && v[4*i+:4] != BCD_MAX) r = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// bcd_stopwatch_ctrl_if: command, limit, count and status signals of the stopwatch controller.
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                Start;
    logic                Stop;
    logic                Clear;
    logic [4*DIGITS-1:0] Limit;
    logic [4*DIGITS-1:0] Bcd;
    logic                Running;
    logic                Done;
    logic                Done_pulse;
    logic                Ovf;

    modport master (
        output Start, Stop, Clear, Limit,
        input  Bcd, Running, Done, Done_pulse, Ovf
    );

    modport slave (
        input  Start, Stop, Clear, Limit,
        output Bcd, Running, Done, Done_pulse, Ovf
    );
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one 0-9 decade with carry-in and combinational carry-out.
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       clear_i,
    input  logic       cin_i,
    output logic [3:0] q_o,
    output logic [3:0] nxt_o,
    output logic       cout_o
);
    logic [3:0] q_q, q_d;

    always_comb begin
        cout_o = cin_i && q_q == BCD_MAX;
        nxt_o  = cin_i ? (q_q == BCD_MAX ? 4'd0 : q_q + 4'd1) : q_q;
        q_d    = clear_i ? 4'd0 : nxt_o;
    end

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) q_q <= 4'd0;
        else        q_q <= q_d;

    assign q_o = q_q;
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: prescaled run/pause/done sequencer driving a cascaded BCD count chain.
module bcd_stopwatch_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000
) (
    input logic                 Clk,
    input logic                 Rst_n,
    bcd_stopwatch_ctrl_if.slave bus
);
    localparam int              PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   TMAX = PW'(TICK_DIV - 1);

    state_e              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                running_q, done_q, done_pulse_q, ovf_q;
    logic [4*DIGITS-1:0] bcd_q, bcd_nxt;
    logic [DIGITS:0]     carry;
    logic                start_ok, cnt_en, tick;

    assign carry[0] = tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit u_dig (
            .Clk    (Clk),
            .Rst_n  (Rst_n),
            .clear_i(bus.Clear),
            .cin_i  (carry[g]),
            .q_o    (bcd_q[4*g+:4]),
            .nxt_o  (bcd_nxt[4*g+:4]),
            .cout_o (carry[g+1])
        );
    end

    // Stop outranks Start, and a Stop in RUN also freezes the prescaler that cycle
    always_comb begin
        start_ok = bus.Start && !bus.Stop;
        cnt_en   = state_q == RUN && !bus.Clear && !bus.Stop;
        tick     = cnt_en && presc_q == TMAX;
        presc_d  = (bus.Clear || tick) ? '0 : cnt_en ? presc_q + PW'(1) : presc_q;
        state_d  = bus.Clear                         ? IDLE
                 : (state_q == RUN && bus.Stop)      ? PAUSE
                 : (state_q == IDLE && start_ok)     ? (bcd_q == bus.Limit ? DONE : RUN)
                 : (state_q == PAUSE && start_ok)    ? RUN
                 : (tick && bcd_nxt == bus.Limit)    ? DONE
                 : state_q;
    end

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            running_q    <= state_d == RUN;
            done_q       <= state_d == DONE;
            done_pulse_q <= state_d == DONE && state_q != DONE;
            ovf_q        <= carry[DIGITS];
        end

    assign bus.Bcd        = bcd_q;
    assign bus.Running    = running_q;
    assign bus.Done       = done_q;
    assign bus.Done_pulse = done_pulse_q;
    assign bus.Ovf        = ovf_q;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: cycle-level reference model feeding an expected-value queue for the stopwatch.
module tb_bcd_stopwatch_ctrl;
    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int W        = 4 * DIGITS;
    localparam int MAXV     = 10 ** DIGITS - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    typedef struct {
        logic [W-1:0] bcd;
        logic         running;
        logic         done;
        logic         dp;
        logic         ovf;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    bcd_stopwatch_ctrl_if #(.DIGITS(DIGITS)) bus ();
    bcd_stopwatch_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;
    int   m_st, m_cnt, m_pre, ovf_seen, done_seen;
    logic m_dp, m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lim_val(input logic [W-1:0] l);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (l[4*i+:4] > 4'd9) return -1;
            v = v * 10 + int'(l[4*i+:4]);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_pre = 0; m_dp = 1'b0; m_ovf = 1'b0;
        sb.delete();
    endtask

    task automatic model(input logic s, input logic p, input logic c);
        logic tk;
        int   lim;
        lim   = lim_val(bus.Limit);
        tk    = m_st == M_RUN && !c && !p && m_pre == TICK_DIV - 1;
        m_dp  = 1'b0;
        m_ovf = 1'b0;
        if (c) begin
            m_st = M_IDLE; m_cnt = 0; m_pre = 0;
        end else begin
            m_ovf = tk && m_cnt == MAXV;
            if (m_st == M_IDLE && s && !p) begin
                m_st = (m_cnt == lim) ? M_DONE : M_RUN;
                m_dp = m_st == M_DONE;
            end else if (m_st == M_PAUSE && s && !p) m_st = M_RUN;
            else if (m_st == M_RUN && p) m_st = M_PAUSE;
            else if (tk) begin
                m_cnt = (m_cnt + 1) % (MAXV + 1);
                m_pre = 0;
                if (m_cnt == lim) begin
                    m_st = M_DONE;
                    m_dp = 1'b1;
                end
            end else if (m_st == M_RUN) m_pre++;
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic c);
        exp_t e;
        @(negedge Clk);
        bus.Start = s; bus.Stop = p; bus.Clear = c;
        model(s, p, c);
        sb.push_back('{to_bcd(m_cnt), m_st == M_RUN, m_st == M_DONE, m_dp, m_ovf});
        @(posedge Clk);
        #1;
        bus.Start = 1'b0; bus.Stop = 1'b0; bus.Clear = 1'b0;
        e = sb.pop_front();
        chk("bcd",        32'(bus.Bcd),        32'(e.bcd));
        chk("running",    32'(bus.Running),    32'(e.running));
        chk("done",       32'(bus.Done),       32'(e.done));
        chk("done_pulse", 32'(bus.Done_pulse), 32'(e.dp));
        chk("ovf",        32'(bus.Ovf),        32'(e.ovf));
        if (bus.Ovf)  ovf_seen++;
        if (bus.Done) done_seen++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Start = 1'b0; bus.Stop = 1'b0; bus.Clear = 1'b0; bus.Limit = '0;
        model_reset();
        #12;
        chk("rst_bcd",  32'(bus.Bcd), 0);
        chk("rst_stat", 32'({bus.Running, bus.Done, bus.Done_pulse, bus.Ovf}), 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        bus.Limit = 8'h99;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("basic_first", 32'(bus.Bcd), 32'h01);
        idle(4);
        chk("basic_second", 32'(bus.Bcd), 32'h02);

        cyc(1'b1, 1'b1, 1'b0);
        chk("prio_run_both", 32'(bus.Running), 0);

        cyc(1'b0, 1'b0, 1'b1);
        bus.Limit = 8'hA0;
        ovf_seen = 0; done_seen = 0;
        cyc(1'b1, 1'b0, 1'b0);
        idle(100 * TICK_DIV + 8);
        chk("ovf_once", 32'(ovf_seen), 1);
        chk("unreachable_no_done", 32'(done_seen), 0);

        cyc(1'b0, 1'b0, 1'b1);
        bus.Limit = 8'h03;
        cyc(1'b1, 1'b0, 1'b0);
        idle(12);
        chk("term_bcd",  32'(bus.Bcd), 32'h03);
        chk("term_done", 32'(bus.Done), 1);
        cyc(1'b1, 1'b0, 1'b0);
        idle(6);
        chk("term_hold", 32'(bus.Bcd), 32'h03);
        cyc(1'b1, 1'b0, 1'b1);
        chk("clear_done_bcd",  32'(bus.Bcd), 0);
        chk("clear_done_stat", 32'({bus.Running, bus.Done}), 0);

        bus.Limit = 8'h00;
        cyc(1'b1, 1'b0, 1'b0);
        chk("limit_zero_done", 32'(bus.Done), 1);
        cyc(1'b0, 1'b0, 1'b1);

        bus.Limit = 8'h99;
        cyc(1'b1, 1'b0, 1'b0);
        idle(6);
        cyc(1'b0, 1'b1, 1'b0);
        idle(10);
        chk("pause_hold", 32'(bus.Bcd), 32'h01);
        cyc(1'b1, 1'b0, 1'b0);
        idle(1);
        chk("resume_wait", 32'(bus.Bcd), 32'h01);
        idle(1);
        chk("resume_inc", 32'(bus.Bcd), 32'h02);
        bus.Limit = 8'h03;
        idle(4);
        chk("limit_change_done", 32'(bus.Done), 1);

        cyc(1'b0, 1'b0, 1'b1);
        bus.Limit = 8'h99;
        cyc(1'b1, 1'b0, 1'b0);
        idle(6);
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        chk("arst_bcd",  32'(bus.Bcd), 0);
        chk("arst_stat", 32'({bus.Running, bus.Done, bus.Done_pulse, bus.Ovf}), 0);
        model_reset();
        @(negedge Clk);
        #2;
        Rst_n = 1'b1;
        idle(3);
        cyc(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("post_rst_run", 32'(bus.Bcd), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Sequencing controller for a cascaded multi-digit BCD count chain, used as a stopwatch/interval timer. It owns a clock prescaler that generates count enables, a run/pause/done state machine driven by Start/Stop/Clear pulses, and a terminal-value comparator. It drives DIGITS cascaded decimal digits and presents the packed BCD value and status to display and system logic.

## Interface
- DIGITS, 4: number of cascaded BCD digits, 1..8.
- TICK_DIV, 50000: Clk cycles per count increment, ≥ 2.
- Clk  in  1  system clock; all logic on the rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Start  in  1  one-cycle pulse: start or resume counting.
- Stop  in  1  one-cycle pulse: pause counting.
- Clear  in  1  one-cycle pulse: zero the count and return to IDLE.
- Limit  in  4*DIGITS  packed BCD terminal value; digit 0 in [3:0]; sampled every cycle.
- Bcd  out  4*DIGITS  packed BCD count; digit 0 in [3:0].
- Running  out  1  high while state is RUN.
- Done  out  1  level, high while state is DONE.
- Done_pulse  out  1  one-cycle strobe on entry to DONE.
- Ovf  out  1  one-cycle strobe when the chain wraps from all-9s to all-0s.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE. Reset values: Bcd=0, prescaler=0, all status outputs 0.
- Command priority in every state: Clear > Stop > Start.
- Clear, any state: go to IDLE, Bcd←0, prescaler←0. Done, Running, and strobes are low on the next cycle.
- IDLE + Start: if Bcd == Limit, go to DONE (Done_pulse). Otherwise go to RUN.
- RUN + Stop: go to PAUSE. Bcd and prescaler hold.
- PAUSE + Start: go to RUN. The prescaler resumes from its held value and is not reset.
- RUN, tick, and next count == Limit: go to DONE on the same edge (Done_pulse). Bcd holds at Limit.
- Ignored commands, with no state change:
  - Stop in IDLE, PAUSE, or DONE.
  - Start in RUN or DONE.
  - Leaving DONE requires Clear.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; holds otherwise.
  - tick = RUN && prescaler == TICK_DIV-1. The prescaler wraps to 0 on tick.
- Count chain:
  - tick is digit 0's carry-in.
  - Digit k increments when its carry-in is 1. It wraps 9→0 and asserts carry-out when carry-in=1 and digit=9.
  - Carry propagates combinationally across all digits in the same cycle.
  - Digit values never exceed 9.
- Ovf pulses when tick occurs with all digits = 9. Counting continues from 0.
- A Limit containing any nibble > 9 is unreachable: the counter runs and wraps, and never reaches DONE.
- A Limit change while in RUN takes effect on the next tick comparison.

## Timing
- Start at edge N moves state to RUN at edge N. Running is high in cycle N+1.
- The first tick after entering RUN from IDLE occurs TICK_DIV cycles later. Bcd increments on that edge.
- A count increment takes one cycle from tick to Bcd; there is no additional pipeline.
- Done, Done_pulse, Ovf, and Running are registered outputs, coincident with the Bcd update.
- Rst_n assertion mid-run clears all state immediately, asynchronously. Release is synchronous in effect: the first transition occurs on an edge after deassertion.

## Structure
- Package bcd_ctrl_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - BCD_MAX = 4'd9;
  - function for a packed all-nines check.
- Sub-module bcd_digit: single 0–9 digit with carry-in, combinational carry-out, and async reset. Instantiated DIGITS times in a generate loop, carry-out k feeding carry-in k+1.
- The controller holds the FSM, prescaler, Limit comparator, and strobe registers.

## Test plan
All scenarios use DIGITS=2, TICK_DIV=4.
- Basic run:
  - Stimulus: reset, Limit=8'h99, Start.
  - Response: Bcd=8'h01 4 cycles after RUN entry, then 8'h02 4 cycles later. Running=1 throughout.
- Decade carry and overflow:
  - Stimulus: run from 8'h09 to 8'h10, with Limit=8'hA0 (unreachable).
  - Response: 8'h99 → 8'h00 with a single-cycle Ovf, and Done never asserts.
- Terminal value:
  - Stimulus: Limit=8'h03, Start.
  - Response: Bcd reaches 8'h03 after 12 cycles. Done=1, Done_pulse one cycle, Running=0, Bcd holds. A further Start is ignored.
- Pause and resume:
  - Stimulus: Stop 2 cycles after a tick, hold 10 cycles, Start.
  - Response: Bcd unchanged during the pause. The next increment occurs 2 cycles after resume, since the prescaler was held.
- Priority and clear:
  - Stimulus: Start+Stop together in RUN; Clear+Start together in DONE.
  - Response: RUN+both goes to PAUSE. DONE+both goes to IDLE with Bcd=8'h00.
- Async reset:
  - Stimulus: Rst_n low mid-count between edges.
  - Response: Bcd=0 and all status outputs 0 immediately. The state after release is IDLE.
